// File: rtl/window9_linebuffer_pkg.sv
// Shared constants and window packing helper for the 9x9 streaming window generator.
package window9_linebuffer_pkg;

    localparam int K         = 9;
    localparam int LINES     = K - 1;
    localparam int WIN_ELEMS = K * K;

    // Bit offset of window element (r,c) inside the flattened window bus.
    function automatic int win_bit_off(input int r, input int c, input int dw);
        return (r * K + c) * dw;
    endfunction

endpackage

// File: rtl/window9_linebuffer_line_buffer_ram.sv
// One-port-per-direction RAM holding the previous LINES rows per column, packed oldest row in the low lane.
module line_buffer_ram #(
    parameter  int DEPTH = 20,
    parameter  int WIDTH = 128,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Asynchronous read returns the old word during a same-address write.
    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/window9_linebuffer.sv
// Raster-order pixel stream in, every fully valid 9x9 window out (stride 1, no padding).
module window9_linebuffer
    import window9_linebuffer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 20,
    parameter int IMG_H      = 20
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              win_valid,
    input  logic                              win_ready,
    output logic [0:WIN_ELEMS*DATA_WIDTH-1]   win_data,
    output logic                              frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = LINES * DATA_WIDTH;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(LINES);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(LINES);

    logic [CW-1:0]                     r_col;
    logic [RW-1:0]                     r_row;
    logic [DATA_WIDTH-1:0]             r_win [K][K];
    logic                              r_win_valid;
    logic [0:WIN_ELEMS*DATA_WIDTH-1]   r_win_data;
    logic                              r_frame_done;

    logic                              w_accept;
    logic                              w_emit;
    logic                              w_col_last;
    logic                              w_row_last;
    logic [LW-1:0]                     w_lb_rdata;
    logic [LW-1:0]                     w_lb_wdata;
    logic [DATA_WIDTH-1:0]             w_win_next [K][K];
    logic [0:WIN_ELEMS*DATA_WIDTH-1]   w_win_flat;

    assign in_ready   = !r_win_valid || win_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_emit     = w_accept && (r_row >= ROW_FIRST_WIN) && (r_col >= COL_FIRST_WIN);

    // Column history ages by one row: drop the oldest lane, append the new pixel on top.
    assign w_lb_wdata = {in_data, w_lb_rdata[LW-1:DATA_WIDTH]};

    line_buffer_ram #(
        .DEPTH (IMG_W),
        .WIDTH (LW)
    ) u_line_buffer_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb_wdata),
        .o_rdata (w_lb_rdata)
    );

    always_comb begin
        w_win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                w_win_next[r][c] = r_win[r][c+1];
            end
        end
        for (int r = 0; r < LINES; r++) begin
            w_win_next[r][K-1] = w_lb_rdata[r*DATA_WIDTH +: DATA_WIDTH];
        end
        w_win_next[K-1][K-1] = in_data;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_win_flat[win_bit_off(r, c, DATA_WIDTH) +: DATA_WIDTH] = w_win_next[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win <= w_win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_win_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // A new window may replace a draining one on the same edge.
            if (w_emit) begin
                r_win_valid <= 1'b1;
                r_win_data  <= w_win_flat;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign win_data   = r_win_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window9_linebuffer.sv
// Directed bench for window9_linebuffer: 20x20 instance plus a 9x9 instance for the single-window case.
module tb_window9_linebuffer;

    localparam int DW  = 16;
    localparam int IW  = 20;
    localparam int IH  = 20;
    localparam int NB  = 81 * DW;
    localparam int WPF = (IH - 8) * (IW - 8);

    typedef logic [0:NB-1] win_t;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, win_valid, win_ready, frame_done;
    logic [DW-1:0] in_data;
    win_t          win_data;

    logic          s_reset, s_in_valid, s_in_ready, s_win_valid, s_win_ready, s_frame_done;
    logic [DW-1:0] s_in_data;
    win_t          s_win_data;

    int            n_vec = 0;
    int            n_err = 0;
    win_t          exp_q[$];
    logic [DW-1:0] pix_q[$];
    win_t          first_win, last_win;
    int            n_win_rx, n_fd, n_cyc;

    always #5 clk = ~clk;

    window9_linebuffer #(.DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .frame_done (frame_done)
    );

    window9_linebuffer #(.DATA_WIDTH(DW), .IMG_W(9), .IMG_H(9)) u_small (
        .clk        (clk),
        .reset      (s_reset),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .win_valid  (s_win_valid),
        .win_ready  (s_win_ready),
        .win_data   (s_win_data),
        .frame_done (s_frame_done)
    );

    function automatic logic [DW-1:0] elem(input win_t w, input int r, input int c);
        return w[(r*9+c)*DW +: DW];
    endfunction

    // Golden model: queue the frame's pixels and every window it must produce.
    task automatic load_frame(input int base);
        logic [DW-1:0] f [IH][IW];
        win_t w;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                f[r][c] = DW'(base + r * IW + c);
                pix_q.push_back(f[r][c]);
            end
        for (int r = 8; r < IH; r++)
            for (int c = 8; c < IW; c++) begin
                w = '0;
                for (int i = 0; i < 9; i++)
                    for (int j = 0; j < 9; j++)
                        w[(i*9+j)*DW +: DW] = f[r-8+i][c-8+j];
                exp_q.push_back(w);
            end
    endtask

    task automatic stream(input int ready_mode, input int gap_pct);
        int            total, idx, budget, bad;
        win_t          prev_data, exp_w;
        logic          prev_stall, acc;
        logic [DW-1:0] mx_o, mx_e;
        total = pix_q.size();
        idx = 0; n_cyc = 0; budget = 4000 + total * 6;
        n_win_rx = 0; n_fd = 0; prev_stall = 1'b0; prev_data = '0;
        @(posedge clk); #1;
        while ((idx < total || exp_q.size() > 0) && n_cyc < budget) begin
            in_valid  = (idx < total) && ($urandom_range(99) >= gap_pct);
            in_data   = in_valid ? pix_q[idx] : DW'($urandom);
            win_ready = (ready_mode == 0) || (n_cyc % 3 == 0);
            @(negedge clk);
            if (prev_stall) begin
                n_vec++;
                if (win_valid !== 1'b1 || win_data !== prev_data) begin
                    n_err++;
                    $display("FAIL stall_hold cycle %0d: win_valid=%b data_changed=%b, required valid=1 unchanged",
                             n_cyc, win_valid, win_data !== prev_data);
                end
            end
            if (win_valid === 1'b1 && !win_ready) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL in_ready_stall cycle %0d: in_ready=%b required 0", n_cyc, in_ready);
                end
            end
            if (frame_done === 1'b1) begin
                n_fd++;
                n_vec++;
                if (win_valid !== 1'b1 || ((n_win_rx + 1) % WPF) != 0) begin
                    n_err++;
                    $display("FAIL frame_done_align: win_valid=%b windows_before=%0d, required valid=1 on last window",
                             win_valid, n_win_rx);
                end
            end
            if (win_valid === 1'b1 && win_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_window %0d: got a window, required none", n_win_rx);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (win_data !== exp_w) begin
                        n_err++;
                        bad = -1;
                        for (int k = 0; k < 81; k++)
                            if (bad < 0 && win_data[k*DW +: DW] !== exp_w[k*DW +: DW]) bad = k;
                        $display("FAIL window %0d elem %0d: got %0d required %0d", n_win_rx, bad,
                                 win_data[bad*DW +: DW], exp_w[bad*DW +: DW]);
                    end
                    mx_o = '0; mx_e = '0;
                    for (int k = 0; k < 81; k++) begin
                        if (win_data[k*DW +: DW] > mx_o) mx_o = win_data[k*DW +: DW];
                        if (exp_w[k*DW +: DW] > mx_e) mx_e = exp_w[k*DW +: DW];
                    end
                    n_vec++;
                    if (mx_o !== mx_e) begin
                        n_err++;
                        $display("FAIL maxpool window %0d: got %0d required %0d", n_win_rx, mx_o, mx_e);
                    end
                end
                if (n_win_rx == 0) first_win = win_data;
                last_win = win_data;
                n_win_rx++;
            end
            prev_stall = (win_valid === 1'b1) && !win_ready;
            prev_data  = win_data;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            n_cyc++;
        end
        in_valid  = 1'b0;
        win_ready = 1'b1;
        n_vec++;
        if (n_cyc >= budget) begin
            n_err++;
            $display("FAIL stream_timeout: %0d of %0d pixels, %0d windows left", idx, total, exp_q.size());
        end
        exp_q.delete();
        pix_q.delete();
    endtask

    task automatic check_counts(input string name, input int wins, input int fds);
        n_vec++;
        if (n_win_rx != wins) begin
            n_err++;
            $display("FAIL %s_windows: got %0d required %0d", name, n_win_rx, wins);
        end
        n_vec++;
        if (n_fd != fds) begin
            n_err++;
            $display("FAIL %s_frame_done: got %0d pulses required %0d", name, n_fd, fds);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; s_reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ctrl: valid=%b done=%b ready=%b required 0 0 1", win_valid, frame_done, in_ready);
        end
        n_vec++;
        if (win_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: elem(0,0)=%0d required all zero", elem(win_data, 0, 0));
        end
        n_vec++;
        if (s_win_valid !== 1'b0 || s_frame_done !== 1'b0 || s_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_small: valid=%b done=%b ready=%b required 0 0 1", s_win_valid, s_frame_done, s_in_ready);
        end
    endtask

    task automatic test_ramp();
        load_frame(0);
        stream(0, 0);
        check_counts("ramp", WPF, 1);
        n_vec++;
        if (elem(first_win, 0, 0) !== 16'd0 || elem(first_win, 8, 8) !== 16'd168) begin
            n_err++;
            $display("FAIL ramp_first: (0,0)=%0d (8,8)=%0d required 0 168", elem(first_win, 0, 0), elem(first_win, 8, 8));
        end
        n_vec++;
        if (elem(last_win, 8, 8) !== 16'd399 || elem(last_win, 0, 0) !== 16'd231) begin
            n_err++;
            $display("FAIL ramp_last: (8,8)=%0d (0,0)=%0d required 399 231", elem(last_win, 8, 8), elem(last_win, 0, 0));
        end
        n_vec++;
        if (n_cyc != IW * IH + 1) begin
            n_err++;
            $display("FAIL ramp_throughput: %0d cycles required %0d", n_cyc, IW * IH + 1);
        end
    endtask

    task automatic test_backpressure();
        load_frame(0);
        stream(1, 0);
        check_counts("backpressure", WPF, 1);
    endtask

    task automatic test_gaps();
        load_frame(30000);
        stream(0, 50);
        check_counts("gaps", WPF, 1);
    endtask

    task automatic test_back_to_back();
        load_frame(1000);
        load_frame(20000);
        stream(0, 0);
        check_counts("back_to_back", 2 * WPF, 2);
        n_vec++;
        if (n_cyc != 2 * IW * IH + 1) begin
            n_err++;
            $display("FAIL back_to_back_gapless: %0d cycles required %0d", n_cyc, 2 * IW * IH + 1);
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        win_ready = 1'b1;
        for (int i = 0; i <= 10 * IW + 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (win_valid !== 1'b1 || elem(win_data, 8, 8) !== DW'(10 * IW + 8)) begin
            n_err++;
            $display("FAIL mid_pending: valid=%b (8,8)=%0d required 1 %0d", win_valid, elem(win_data, 8, 8), 10 * IW + 8);
        end
        win_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        win_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1 || win_data !== '0) begin
            n_err++;
            $display("FAIL mid_reset: valid=%b done=%b ready=%b data_zero=%b required 0 0 1 1",
                     win_valid, frame_done, in_ready, win_data === '0);
        end
        load_frame(5000);
        stream(1, 30);
        check_counts("after_reset", WPF, 1);
    endtask

    task automatic test_small();
        int   idx, nw, nf, bad;
        logic acc;
        idx = 0; nw = 0; nf = 0;
        s_win_ready = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            s_in_valid = (idx < 81);
            s_in_data  = DW'(100 + idx);
            @(negedge clk);
            if (s_frame_done === 1'b1) begin
                nf++;
                n_vec++;
                if (s_win_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL small_done_align: win_valid=%b required 1", s_win_valid);
                end
            end
            if (s_win_valid === 1'b1) begin
                nw++;
                bad = -1;
                for (int k = 0; k < 81; k++)
                    if (bad < 0 && s_win_data[k*DW +: DW] !== DW'(100 + k)) bad = k;
                n_vec++;
                if (bad >= 0) begin
                    n_err++;
                    $display("FAIL small_window elem %0d: got %0d required %0d", bad, s_win_data[bad*DW +: DW], 100 + bad);
                end
            end
            acc = s_in_valid && s_in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        s_in_valid = 1'b0;
        n_vec++;
        if (nw != 1 || nf != 1) begin
            n_err++;
            $display("FAIL small_counts: windows=%0d frame_done=%0d required 1 1", nw, nf);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; win_ready = 1'b1;
        s_reset = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_win_ready = 1'b1;
        test_reset();
        test_ramp();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
